// File: rtl/miner_host_link.sv
// Host end of the miner UART link: sends 80-byte jobs MSB byte first
// and reassembles 8-byte nonces returned by the miner.
module miner_host_link #(
   parameter int JOB_BYTES   = 80,
   parameter int NONCE_BYTES = 8,
   parameter int RX_TIMEOUT  = 20000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [JOB_BYTES*8-1:0]   job,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     transmit,
   output logic [7:0]               tx_byte,
   input  logic                     tx_active,
   input  logic                     received,
   input  logic [7:0]               rx_byte,
   input  logic                     recv_error,
   output logic [NONCE_BYTES*8-1:0] nonce,
   output logic                     nonce_valid,
   output logic [15:0]              nonce_count,
   output logic [7:0]               drop_count
);

   localparam int NW = NONCE_BYTES * 8;
   localparam int IW = $clog2(JOB_BYTES);
   localparam int RW = $clog2(NONCE_BYTES);
   localparam int GW = $clog2(RX_TIMEOUT + 1);

   typedef enum logic [1:0] {
      T_IDLE,
      T_ISSUE,
      T_WAIT_HI,
      T_WAIT_LO
   } tstate_t;

   tstate_t                   r_tstate;
   logic [JOB_BYTES-1:0][7:0] r_hold;
   logic [IW-1:0]             r_idx;
   logic [IW-1:0]             w_sel;

   // Byte k of the job sits in the packed slot JOB_BYTES-1-k.
   assign w_sel = IW'(JOB_BYTES - 1) - r_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tstate <= T_IDLE;
         r_hold   <= '0;
         r_idx    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         transmit <= 1'b0;
         tx_byte  <= 8'h00;
      end else begin
         done     <= 1'b0;
         transmit <= 1'b0;
         unique case (r_tstate)
            T_IDLE: begin
               if (start && !done) begin
                  r_hold   <= job;
                  r_idx    <= '0;
                  busy     <= 1'b1;
                  r_tstate <= T_ISSUE;
               end
            end
            T_ISSUE: begin
               tx_byte  <= r_hold[w_sel];
               transmit <= 1'b1;
               r_tstate <= T_WAIT_HI;
            end
            T_WAIT_HI: begin
               if (tx_active) begin
                  r_tstate <= T_WAIT_LO;
               end
            end
            T_WAIT_LO: begin
               if (!tx_active) begin
                  if (r_idx == IW'(JOB_BYTES - 1)) begin
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     r_tstate <= T_IDLE;
                  end else begin
                     r_idx    <= r_idx + 1'b1;
                     r_tstate <= T_ISSUE;
                  end
               end
            end
            default: r_tstate <= T_IDLE;
         endcase
      end
   end

   logic [RW-1:0] r_ridx;
   logic [NW-1:0] r_sr;
   logic [GW-1:0] r_gap;
   logic [NW-1:0] w_sr_next;
   logic [7:0]    w_drop_next;
   logic          w_mid_frame;

   assign w_sr_next   = {r_sr[NW-9:0], rx_byte};
   assign w_drop_next = (drop_count == 8'hFF) ? 8'hFF : drop_count + 8'd1;
   assign w_mid_frame = (r_ridx != '0);

   // Error beats a byte in the same cycle; a byte beats the timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ridx      <= '0;
         r_sr        <= '0;
         r_gap       <= '0;
         nonce       <= '0;
         nonce_valid <= 1'b0;
         nonce_count <= 16'h0000;
         drop_count  <= 8'h00;
      end else begin
         nonce_valid <= 1'b0;
         if (recv_error) begin
            r_gap <= '0;
            if (w_mid_frame) begin
               r_ridx     <= '0;
               drop_count <= w_drop_next;
            end
         end else if (received) begin
            r_sr  <= w_sr_next;
            r_gap <= '0;
            if (r_ridx == RW'(NONCE_BYTES - 1)) begin
               nonce       <= w_sr_next;
               nonce_valid <= 1'b1;
               nonce_count <= nonce_count + 16'd1;
               r_ridx      <= '0;
            end else begin
               r_ridx <= r_ridx + 1'b1;
            end
         end else if (w_mid_frame) begin
            if (r_gap == GW'(RX_TIMEOUT - 1)) begin
               r_ridx     <= '0;
               r_gap      <= '0;
               drop_count <= w_drop_next;
            end else begin
               r_gap <= r_gap + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/miner_host_link.md
Name: miner_host_link

Overview:
- Host-side end of the miner UART job/nonce protocol.
- Serializes an 80-byte job (72-byte blob followed by 8-byte target) onto a byte-level UART transmitter.
- Reassembles 8-byte nonces returned by a miner from the UART receiver.
- Used for FPGA-to-FPGA chaining and hardware-in-loop self-test, clocked on the 100 MHz core clock.

Parameters:
- JOB_BYTES, 80, number of bytes per job frame.
- NONCE_BYTES, 8, number of bytes per nonce frame.
- RX_TIMEOUT, 20000, maximum clk cycles allowed between received bytes of one nonce frame before the partial frame is discarded.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset; asynchronous, active-high.
- job  input  640  job word; bits [639:64] are the blob, [63:0] the target.
- start  input  1  one-cycle strobe that launches transmission of job.
- busy  output  1  high while a job frame is being sent.
- done  output  1  one-cycle pulse after the last job byte completes.
- transmit  output  1  one-cycle strobe to the UART transmitter.
- tx_byte  output  8  byte presented with transmit.
- tx_active  input  1  UART is_transmitting.
- received  input  1  UART one-cycle byte-received strobe.
- rx_byte  input  8  UART received byte.
- recv_error  input  1  UART framing-error strobe.
- nonce  output  64  last complete nonce.
- nonce_valid  output  1  one-cycle pulse when nonce updates.
- nonce_count  output  16  completed nonces, wraps.
- drop_count  output  8  discarded partial frames, saturates at 255.

Behaviour:
- Reset (async, immediate): busy=0, done=0, transmit=0, tx_byte=0, nonce=0, nonce_valid=0, nonce_count=0, drop_count=0. Both FSMs go to idle; byte indices clear; a job in flight is abandoned with no done pulse.
- Byte order: MSB byte first for both directions. Job byte k is job[639-8k -: 8], k=0..79. The first received byte lands in nonce[63:56].
- TX FSM states: T_IDLE, T_ISSUE, T_WAIT_HI, T_WAIT_LO.
  - T_IDLE: on start, latch job into a 640-bit holding register, set idx=0, busy=1, go to T_ISSUE. A start while busy=1 is ignored; the holding register is unchanged.
  - T_ISSUE: drive tx_byte with byte idx and pulse transmit for exactly 1 cycle, then go to T_WAIT_HI. tx_byte holds its value until the next issue.
  - T_WAIT_HI: wait for tx_active=1, then go to T_WAIT_LO.
  - T_WAIT_LO: wait for tx_active=0.
    - If idx=JOB_BYTES-1: busy=0, done=1 for one cycle, go to T_IDLE.
    - Else: idx+1, go to T_ISSUE.
  - Minimum spacing between transmit pulses is 3 cycles.
  - A start arriving in the same cycle that done is asserted is ignored.
- RX FSM: independent of TX (full duplex). Holds a byte index r (0..NONCE_BYTES-1), a 64-bit shift register and a gap counter.
  - On received: shift register <= {sr[55:0], rx_byte}; gap counter clears.
    - If r=NONCE_BYTES-1: on the next cycle nonce <= assembled value, nonce_valid=1 for one cycle, nonce_count+1 (mod 2^16), r=0.
    - Else: r+1.
  - Gap counter increments every cycle while r≠0. When it reaches RX_TIMEOUT: r=0, drop_count+1 (saturating), counter clears.
  - recv_error with r≠0: discard the partial frame, r=0, drop_count+1.
  - recv_error with r=0: no count.
  - If received and recv_error occur in the same cycle, recv_error wins: the byte is dropped and the frame resets.
  - The timeout and a received strobe coinciding: received wins and the gap counter clears.
- Latency: nonce_valid asserts 1 cycle after the 8th received strobe.

Test Plan:
- Job frame: job = 640'h00..4F (byte k = k), one start pulse, a UART model asserting tx_active for 10 cycles per byte -> exactly 80 transmit pulses with tx_byte = 0x00, 0x01, …, 0x4F in order; done pulses once; busy falls in the same cycle as done.
- Start while busy: start at byte 5 with a different job -> byte stream unchanged; still 80 bytes; a single done.
- Nonce assembly: 8 received strobes with bytes 0x11, 0x22, …, 0x88, spaced 100 cycles -> nonce = 64'h1122334455667788; nonce_valid for 1 cycle; nonce_count = 1.
- Timeout: 3 bytes, then a gap of RX_TIMEOUT+5 cycles, then 8 bytes 0xA0..0xA7 -> drop_count = 1; nonce = 64'hA0A1A2A3A4A5A6A7; nonce_count = 1.
- recv_error at byte 4 (with a simultaneous received strobe), then a full frame -> drop_count = 1; only the clean frame is reported. 300 forced errors -> drop_count stays at 255.
- Reset at byte 40 of a job and at byte 3 of a nonce -> all outputs return to reset values immediately; no done or nonce_valid; a following start sends the full 80 bytes from byte 0.
